lcd_nibble_sequencer: RTL and testbench

- Physical-bus sequencer for the 4-bit character-LCD interface.
- Accepts one command or data byte per start/busy handshake from the configure FSM and sends it as two nibbles, high nibble first.
- Generates the setup, enable-pulse, hold and gap timing the LCD needs, then pulses done.
- Sits between the configure FSM and the LCD pins. It is the only driver of lcd_e/lcd_rs/lcd_rw/lcd_d.

---
 rtl/lcd_nibble_sequencer.sv | 145 ++++++++++++++
 tb/tb_lcd_nibble_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_sequencer.sv
// Physical-bus sequencer for a 4-bit character LCD: sends one byte per start/busy handshake as two timed nibbles.
// Optional LCD_SINGLE_NIBBLE_EN adds a nib_only input for single-nibble (power-on init) transfers.
module lcd_nibble_sequencer #(
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned E_HIGH_CYC     = 12,
    parameter int unsigned HOLD_CYC       = 1,
    parameter int unsigned NIBBLE_GAP_CYC = 50,
    parameter int unsigned BYTE_GAP_CYC   = 2000,
    parameter int unsigned LONG_GAP_CYC   = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] data_in,
`ifdef LCD_SINGLE_NIBBLE_EN
    input  logic       nib_only,
`endif
    output logic       busy,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_d
);

    localparam int unsigned CW = $clog2(LONG_GAP_CYC + 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC);
    localparam logic [CW-1:0] L_EHIGH = CW'(E_HIGH_CYC);
    localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC);
    localparam logic [CW-1:0] L_NGAP  = CW'(NIBBLE_GAP_CYC);
    localparam logic [CW-1:0] L_BGAP  = CW'(BYTE_GAP_CYC);
    localparam logic [CW-1:0] L_LGAP  = CW'(LONG_GAP_CYC);

    typedef enum logic [3:0] {
        IDLE, HI_SETUP, HI_EN, HI_HOLD, NIB_GAP, LO_SETUP, LO_EN, LO_HOLD, BYTE_GAP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_byte;
    logic          r_rs;
    logic          w_last;
    logic          w_single;
    logic          w_long;
    logic [CW-1:0] w_gap_len;

`ifdef LCD_SINGLE_NIBBLE_EN
    logic r_nib_only;
    assign w_single = r_nib_only;
`else
    assign w_single = 1'b0;
`endif

    assign w_last = (r_cnt == ONE);
    // Clear (0x01) and home (0x02/0x03) need the long settle time; single nibbles never do.
    assign w_long    = !r_rs && (r_byte[7:2] == 6'd0) && !w_single;
    assign w_gap_len = w_long ? L_LGAP : L_BGAP;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_rs    <= 1'b0;
`ifdef LCD_SINGLE_NIBBLE_EN
            r_nib_only <= 1'b0;
`endif
            busy    <= 1'b0;
            done    <= 1'b0;
            lcd_e   <= 1'b0;
            lcd_rs  <= 1'b0;
            lcd_rw  <= 1'b0;
            lcd_d   <= '0;
        end else begin
            done   <= 1'b0;
            lcd_rw <= 1'b0;
            if (r_state != IDLE && !w_last) begin
                r_cnt <= r_cnt - ONE;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_byte  <= data_in;
                        r_rs    <= rs_in;
`ifdef LCD_SINGLE_NIBBLE_EN
                        r_nib_only <= nib_only;
`endif
                        lcd_rs  <= rs_in;
                        lcd_d   <= data_in[7:4];
                        busy    <= 1'b1;
                        r_cnt   <= L_SETUP;
                        r_state <= HI_SETUP;
                    end
                end
                HI_SETUP: if (w_last) begin
                    lcd_e   <= 1'b1;
                    r_cnt   <= L_EHIGH;
                    r_state <= HI_EN;
                end
                HI_EN: if (w_last) begin
                    lcd_e   <= 1'b0;
                    r_cnt   <= L_HOLD;
                    r_state <= HI_HOLD;
                end
                HI_HOLD: if (w_last) begin
                    if (w_single) begin
                        r_cnt   <= w_gap_len;
                        r_state <= BYTE_GAP;
                    end else begin
                        r_cnt   <= L_NGAP;
                        r_state <= NIB_GAP;
                    end
                end
                NIB_GAP: if (w_last) begin
                    lcd_d   <= r_byte[3:0];
                    r_cnt   <= L_SETUP;
                    r_state <= LO_SETUP;
                end
                LO_SETUP: if (w_last) begin
                    lcd_e   <= 1'b1;
                    r_cnt   <= L_EHIGH;
                    r_state <= LO_EN;
                end
                LO_EN: if (w_last) begin
                    lcd_e   <= 1'b0;
                    r_cnt   <= L_HOLD;
                    r_state <= LO_HOLD;
                end
                LO_HOLD: if (w_last) begin
                    r_cnt   <= w_gap_len;
                    r_state <= BYTE_GAP;
                end
                BYTE_GAP: if (w_last) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Self-checking bench for lcd_nibble_sequencer: cycle model plus directed transfers with literal expectations.
// Long gap is shortened so the whole run stays small; set LCD_SINGLE_NIBBLE_EN to cover nib_only.
module tb_lcd_nibble_sequencer;

    localparam int S   = 2;
    localparam int E   = 12;
    localparam int H   = 1;
    localparam int G   = 50;
    localparam int BG  = 2000;
    localparam int LG  = 8200;
    localparam int NIB = S + E + H;

    logic       clk = 1'b0;
    logic       reset, start, rs_in, nib_only;
    logic [7:0] data_in;
    logic       busy, done, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_d;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    lcd_nibble_sequencer #(
        .SETUP_CYC(S), .E_HIGH_CYC(E), .HOLD_CYC(H),
        .NIBBLE_GAP_CYC(G), .BYTE_GAP_CYC(BG), .LONG_GAP_CYC(LG)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rs_in(rs_in), .data_in(data_in),
`ifdef LCD_SINGLE_NIBBLE_EN
        .nib_only(nib_only),
`endif
        .busy(busy), .done(done), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
    );

    // Model: a transfer is a timeline indexed by m_k (cycles since capture); outputs are windows on it.
    bit         m_active = 0, m_done = 0, m_nib = 0, m_rs = 0;
    int         m_k = 0, m_total = 0;
    logic [7:0] m_b = '0;
    logic [3:0] m_d = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_done = 0; m_d = '0; m_rs = 0;
        end else begin
            m_done = 0;
            if (m_active) begin
                m_k++;
                if (m_k == m_total) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end else if (start) begin
                m_active = 1;
                m_k      = 0;
                m_b      = data_in;
                m_rs     = rs_in;
`ifdef LCD_SINGLE_NIBBLE_EN
                m_nib    = nib_only;
`else
                m_nib    = 0;
`endif
                if (m_nib) m_total = NIB + BG;
                else       m_total = 2 * NIB + G + ((!rs_in && data_in[7:2] == 6'd0) ? LG : BG);
            end
            if (m_active) m_d = (m_nib || m_k < NIB + G) ? m_b[7:4] : m_b[3:0];
        end
    end

    always @(negedge clk) begin
        logic [8:0] got, exp;
        bit         e;
        if (chk_en) begin
            e = m_active && ((m_k >= S && m_k < S + E) ||
                             (!m_nib && m_k >= NIB + G + S && m_k < NIB + G + S + E));
            exp = {m_active, m_done, e, m_rs, 1'b0, m_d};
            got = {busy, done, lcd_e, lcd_rs, lcd_rw, lcd_d};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL outputs t=%0t {busy,done,e,rs,rw,d} got %b expected %b", $time, got, exp);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic xfer(input logic rs, input logic [7:0] b, input logic nib, input int exp_lat,
                        input int exp_pulses, input logic [3:0] exp_hi, input logic [3:0] exp_lo,
                        input int intrude_at);
        int c, pulses, wid;
        logic [3:0] dv0, dv1;
        bit saw5;
        start = 1'b1; rs_in = rs; data_in = b; nib_only = nib;
        @(posedge clk); #1;
        start = 1'b0; rs_in = ~rs; data_in = ~b; nib_only = ~nib;
        check("busy_after_capture", busy, 1);
        c = 0; pulses = 0; wid = 0; saw5 = 0; dv0 = '0; dv1 = '0;
        do begin
            @(negedge clk);
            c++;
            if (c == intrude_at) begin
                start = 1'b1; rs_in = 1'b1; data_in = 8'h55;
            end else if (c == intrude_at + 1) begin
                start = 1'b0;
            end
            if (lcd_d == 4'h5) saw5 = 1;
            if (lcd_e) begin
                wid++;
                if (wid == 1) begin
                    if (pulses == 0) dv0 = lcd_d;
                    else             dv1 = lcd_d;
                end
            end else if (wid > 0) begin
                check("e_pulse_width", wid, E);
                pulses++;
                wid = 0;
            end
        end while (!done && c < 20000);
        check("done_latency", c, exp_lat);
        check("busy_in_done_cycle", busy, 0);
        check("e_pulse_count", pulses, exp_pulses);
        check("hi_nibble", dv0, exp_hi);
        if (exp_pulses == 2) check("lo_nibble", dv1, exp_lo);
        if (intrude_at > 0) check("ignored_start_no_5", saw5, 0);
    endtask

    initial begin
        int ndone;
        reset = 1'b1; start = 1'b1; rs_in = 1'b1; data_in = 8'h41; nib_only = 1'b0;
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_e", lcd_e, 0);
        check("reset_rs", lcd_rs, 0);
        check("reset_rw", lcd_rw, 0);
        check("reset_d", lcd_d, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("start_during_reset_ignored", busy, 0);

        repeat (2) @(negedge clk);
        xfer(1'b1, 8'h41, 1'b0, 2081, 2, 4'h4, 4'h1, 0);
        repeat (3) @(negedge clk);
        xfer(1'b0, 8'h01, 1'b0, 8281, 2, 4'h0, 4'h1, 0);
        repeat (3) @(negedge clk);
        xfer(1'b0, 8'h28, 1'b0, 2081, 2, 4'h2, 4'h8, 0);
        xfer(1'b0, 8'h03, 1'b0, 8281, 2, 4'h0, 4'h3, 0);
        xfer(1'b0, 8'h04, 1'b0, 2081, 2, 4'h0, 4'h4, 0);
        xfer(1'b1, 8'h01, 1'b0, 2081, 2, 4'h0, 4'h1, 0);
        repeat (2) @(negedge clk);
        xfer(1'b1, 8'h41, 1'b0, 2081, 2, 4'h4, 4'h1, 100);
        xfer(1'b0, 8'h28, 1'b0, 2081, 2, 4'h2, 4'h8, 0);

        // Reset in the middle of the first E pulse.
        repeat (2) @(negedge clk);
        start = 1'b1; rs_in = 1'b1; data_in = 8'h41;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("e_high_before_reset", lcd_e, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_e", lcd_e, 0);
        check("reset_mid_busy", busy, 0);
        reset = 1'b0;
        ndone = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_reset", ndone, 0);
        xfer(1'b1, 8'h41, 1'b0, 2081, 2, 4'h4, 4'h1, 0);

`ifdef LCD_SINGLE_NIBBLE_EN
        repeat (2) @(negedge clk);
        xfer(1'b0, 8'h30, 1'b1, 2016, 1, 4'h3, 4'h0, 0);
        repeat (2) @(negedge clk);
        xfer(1'b0, 8'h02, 1'b1, 2016, 1, 4'h0, 4'h0, 0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
